// File: rtl/filter_coeff_sequencer_if.sv
// filter_coeff_sequencer_if: coefficient write/commit bus between the config host and the sequencer.
interface filter_coeff_sequencer_if #(parameter int WIDTH = 64);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic             cfg_commit;
    logic             cfg_err;
    modport master (output cfg_valid, cfg_addr, cfg_data, cfg_commit, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_addr, cfg_data, cfg_commit, output cfg_ready, cfg_err);
endinterface

// File: rtl/filter_coeff_sequencer.sv
// filter_coeff_sequencer: shadow/active coefficient banks, commit-triggered flush and warm-up pacing for the IIR filter.
// Optional FILT_COEFF_READBACK_EN adds rd_addr/rd_data/rd_mask shadow-bank readback.
module filter_coeff_sequencer #(
    parameter int WIDTH          = 64,
    parameter int FLUSH_CYCLES   = 2,
    parameter int WARMUP_SAMPLES = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    filter_coeff_sequencer_if.slave cfg,
    input  logic                    adc_strobe,
    input  logic                    filt_valid_out,
    output logic [WIDTH-1:0]        b0,
    output logic [WIDTH-1:0]        b1,
    output logic [WIDTH-1:0]        b2,
    output logic [WIDTH-1:0]        b3,
    output logic [WIDTH-1:0]        b4,
    output logic [WIDTH-1:0]        b5,
    output logic [WIDTH-1:0]        b6,
    output logic [WIDTH-1:0]        a3,
    output logic [WIDTH-1:0]        a6,
    output logic                    coefficients_ready,
    output logic                    sample_ready,
    output logic                    y_valid,
    output logic [7:0]              drop_cnt
`ifdef FILT_COEFF_READBACK_EN
    ,
    input  logic [3:0]              rd_addr,
    output logic [WIDTH-1:0]        rd_data,
    output logic [8:0]              rd_mask
`endif
);
    localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {EMPTY, FLUSH, WARMUP, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow    [9];
    logic [WIDTH-1:0] shadow_nx [9];
    logic [WIDTH-1:0] act       [9];
    logic [8:0]       mask, mask_nx;
    logic [FW-1:0]    fcnt;
    logic [7:0]       wcnt;
    logic             legal, commit_req, commit_ok, err_nx, drop;

    // A same-cycle write is folded into shadow_nx/mask_nx so a commit sees it.
    always_comb begin
        legal     = cfg.cfg_addr <= 4'd8;
        shadow_nx = shadow;
        mask_nx   = mask;
        for (int i = 0; i < 9; i++) begin
            if (cfg.cfg_valid && cfg.cfg_ready && cfg.cfg_addr == 4'(i)) begin
                shadow_nx[i] = cfg.cfg_data;
                mask_nx[i]   = 1'b1;
            end
        end
        commit_req = cfg.cfg_commit && cfg.cfg_ready;
        commit_ok  = commit_req && &mask_nx;
        err_nx     = (cfg.cfg_valid && cfg.cfg_ready && !legal) || (commit_req && !(&mask_nx));
        drop       = adc_strobe && (state == EMPTY || state == FLUSH) && drop_cnt != 8'hFF;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= EMPTY;
            shadow             <= '{default: '0};
            act                <= '{default: '0};
            mask               <= '0;
            fcnt               <= '0;
            wcnt               <= '0;
            drop_cnt           <= '0;
            cfg.cfg_ready      <= 1'b1;
            cfg.cfg_err        <= 1'b0;
            coefficients_ready <= 1'b0;
        end else begin
            shadow      <= shadow_nx;
            mask        <= commit_ok ? '0 : mask_nx;
            cfg.cfg_err <= err_nx;
            drop_cnt    <= drop ? drop_cnt + 8'd1 : drop_cnt;
            if (commit_ok) begin
                act                <= shadow_nx;
                state              <= FLUSH;
                fcnt               <= FW'(FLUSH_CYCLES - 1);
                wcnt               <= '0;
                cfg.cfg_ready      <= 1'b0;
                coefficients_ready <= 1'b0;
            end else if (state == FLUSH) begin
                fcnt               <= fcnt == '0 ? fcnt : fcnt - 1'b1;
                state              <= fcnt == '0 ? WARMUP : FLUSH;
                cfg.cfg_ready      <= fcnt == '0;
                coefficients_ready <= fcnt == '0;
            end else if (state == WARMUP && adc_strobe) begin
                wcnt  <= wcnt + 8'd1;
                state <= wcnt == 8'(WARMUP_SAMPLES - 1) ? RUN : WARMUP;
            end
        end
    end

    assign sample_ready = adc_strobe && (state == WARMUP || state == RUN);
    assign y_valid      = filt_valid_out && state == RUN;
    assign b0 = act[0];
    assign b1 = act[1];
    assign b2 = act[2];
    assign b3 = act[3];
    assign b4 = act[4];
    assign b5 = act[5];
    assign b6 = act[6];
    assign a3 = act[7];
    assign a6 = act[8];

`ifdef FILT_COEFF_READBACK_EN
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < 9; i++) rd_data = rd_addr == 4'(i) ? shadow[i] : rd_data;
    end
    assign rd_mask = mask;
`endif
endmodule

// File: tb/tb_filter_coeff_sequencer.sv
// tb_filter_coeff_sequencer: scoreboard bench; a behavioural model pushes expected outputs as stimulus
// is driven and they are popped against the DUT when it responds.
module tb_filter_coeff_sequencer;
    localparam int S_EMPTY = 0, S_FLUSH = 1, S_WARMUP = 2, S_RUN = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        adc_strobe = 1'b0;
    logic        filt_valid_out = 1'b0;
    logic [63:0] b0, b1, b2, b3, b4, b5, b6, a3, a6;
    logic        coefficients_ready, sample_ready, y_valid;
    logic [7:0]  drop_cnt;
`ifdef FILT_COEFF_READBACK_EN
    logic [3:0]  rd_addr = 4'd0;
    logic [63:0] rd_data;
    logic [8:0]  rd_mask;
`endif

    filter_coeff_sequencer_if #(.WIDTH(64)) cfg_bus ();

    filter_coeff_sequencer dut (
        .clk(clk), .reset_n(reset_n), .cfg(cfg_bus),
        .adc_strobe(adc_strobe), .filt_valid_out(filt_valid_out),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .a3(a3), .a6(a6),
        .coefficients_ready(coefficients_ready), .sample_ready(sample_ready),
        .y_valid(y_valid), .drop_cnt(drop_cnt)
`ifdef FILT_COEFF_READBACK_EN
        , .rd_addr(rd_addr), .rd_data(rd_data), .rd_mask(rd_mask)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;

    sb_t         sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_state, m_left, m_warm, m_drop;
    logic [63:0] m_sh[9];
    logic [63:0] m_act[9];
    logic [8:0]  m_mask;
    logic        seen_y;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [63:0] act);
        sb_t e;
        if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
        else begin
            e = sb.pop_front();
            check(e.tag, act, e.exp);
        end
    endtask

    function automatic logic [63:0] coef(input int i);
        case (i)
            0: return b0;
            1: return b1;
            2: return b2;
            3: return b3;
            4: return b4;
            5: return b5;
            6: return b6;
            7: return a3;
            default: return a6;
        endcase
    endfunction

    task automatic model_reset();
        m_state = S_EMPTY;
        m_left  = 0;
        m_warm  = 0;
        m_drop  = 0;
        m_mask  = '0;
        for (int i = 0; i < 9; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
    endtask

    // Expected combinational outputs come from the pre-edge state, registered ones from the post-edge state.
    task automatic model_step();
        logic legal, acc, ok, err;
        int   a;
        a     = int'(cfg_bus.cfg_addr);
        legal = a <= 8;
        acc   = m_state != S_FLUSH;
        push("sample_ready", 64'(adc_strobe && m_state >= S_WARMUP));
        push("y_valid", 64'(filt_valid_out && m_state == S_RUN));
        if (cfg_bus.cfg_valid && acc && legal) begin
            m_sh[a]   = cfg_bus.cfg_data;
            m_mask[a] = 1'b1;
        end
        err = (cfg_bus.cfg_valid && acc && !legal) || (cfg_bus.cfg_commit && acc && m_mask != 9'h1FF);
        ok  = cfg_bus.cfg_commit && acc && m_mask == 9'h1FF;
        if (adc_strobe && m_state <= S_FLUSH && m_drop < 255) m_drop++;
        if (ok) begin
            m_act   = m_sh;
            m_mask  = '0;
            m_state = S_FLUSH;
            m_left  = 2;
            m_warm  = 0;
        end else if (m_state == S_FLUSH) begin
            m_left--;
            if (m_left == 0) m_state = S_WARMUP;
        end else if (m_state == S_WARMUP && adc_strobe) begin
            m_warm++;
            if (m_warm == 8) m_state = S_RUN;
        end
        push("cfg_err", 64'(err));
        push("cfg_ready", 64'(m_state != S_FLUSH));
        push("coefficients_ready", 64'(m_state >= S_WARMUP));
        push("drop_cnt", 64'(m_drop));
        for (int i = 0; i < 9; i++) push($sformatf("coef%0d", i), m_act[i]);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        seen_y = y_valid;
        pop_cmp(64'(sample_ready));
        pop_cmp(64'(y_valid));
        @(posedge clk);
        #1;
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_commit = 1'b0;
        adc_strobe         = 1'b0;
        pop_cmp(64'(cfg_bus.cfg_err));
        pop_cmp(64'(cfg_bus.cfg_ready));
        pop_cmp(64'(coefficients_ready));
        pop_cmp(64'(drop_cnt));
        for (int i = 0; i < 9; i++) pop_cmp(coef(i));
    endtask

    task automatic write_cfg(input logic [3:0] addr, input logic [63:0] data, input logic commit);
        cfg_bus.cfg_valid  = 1'b1;
        cfg_bus.cfg_addr   = addr;
        cfg_bus.cfg_data   = data;
        cfg_bus.cfg_commit = commit;
        tick();
    endtask

    task automatic commit_only();
        cfg_bus.cfg_commit = 1'b1;
        tick();
    endtask

    task automatic strobe_run(input int n, output int first);
        first = 0;
        for (int k = 1; k <= n; k++) begin
            adc_strobe = 1'b1;
            tick();
            if (seen_y && first == 0) first = k;
            repeat (3) tick();
        end
    endtask

    initial begin
        int n, first;
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_commit = 1'b0;
        cfg_bus.cfg_addr   = '0;
        cfg_bus.cfg_data   = '0;
        model_reset();
        #12;
        check("rst_cfg_ready", 64'(cfg_bus.cfg_ready), 64'd1);
        check("rst_cfg_err", 64'(cfg_bus.cfg_err), 64'd0);
        check("rst_coef_ready", 64'(coefficients_ready), 64'd0);
        check("rst_b0", b0, 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Incomplete bank, illegal address, then completion and a good commit.
        for (int i = 0; i < 8; i++) write_cfg(4'(i), 64'(i + 1), 1'b0);
        commit_only();
        check("incomplete_commit_err", 64'(cfg_bus.cfg_err), 64'd1);
        check("incomplete_commit_b0", b0, 64'd0);
        write_cfg(4'd12, 64'hDEAD, 1'b0);
        check("illegal_addr_err", 64'(cfg_bus.cfg_err), 64'd1);
`ifdef FILT_COEFF_READBACK_EN
        check("rd_mask_after_illegal", 64'(rd_mask), 64'h0FF);
`endif
        write_cfg(4'd8, 64'd9, 1'b0);
        commit_only();
        check("commit_err", 64'(cfg_bus.cfg_err), 64'd0);
        check("commit_b0", b0, 64'd1);
        check("commit_b3", b3, 64'd4);
        check("commit_a6", a6, 64'd9);
        n = coefficients_ready ? 0 : 1;
        adc_strobe = 1'b1;
        tick();
        check("flush_drop_cnt", 64'(drop_cnt), 64'd1);
        while (!coefficients_ready && n < 20) begin
            n++;
            tick();
        end
        check("flush_len", 64'(n), 64'd2);

        // Warm-up with steady filter valid: trusted from the ninth strobe.
        filt_valid_out = 1'b1;
        strobe_run(12, first);
        check("first_y_valid", 64'(first), 64'd9);

        // RUN: refill bank, write addr 3 and commit together.
        for (int i = 0; i < 9; i++) if (i != 3) write_cfg(4'(i), 64'h10 + 64'(i), 1'b0);
        write_cfg(4'd3, 64'h55, 1'b1);
        check("same_cycle_b3", b3, 64'h55);
        check("same_cycle_b0", b0, 64'h10);
        check("same_cycle_coef_ready", 64'(coefficients_ready), 64'd0);
        repeat (2) tick();
        strobe_run(10, first);
        check("recommit_first_y_valid", 64'(first), 64'd9);

        // Async reset during WARMUP, then a commit with no rewrites must fail.
        for (int i = 0; i < 9; i++) write_cfg(4'(i), 64'h20 + 64'(i), 1'b0);
        commit_only();
        repeat (2) tick();
        strobe_run(3, first);
        #2;
        reset_n    = 1'b0;
        adc_strobe = 1'b1;
        #1;
        check("async_cfg_ready", 64'(cfg_bus.cfg_ready), 64'd1);
        check("async_coef_ready", 64'(coefficients_ready), 64'd0);
        check("async_sample_ready", 64'(sample_ready), 64'd0);
        check("async_y_valid", 64'(y_valid), 64'd0);
        check("async_b0", b0, 64'd0);
        check("async_drop", 64'(drop_cnt), 64'd0);
        model_reset();
        adc_strobe = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        commit_only();
        check("post_reset_commit_err", 64'(cfg_bus.cfg_err), 64'd1);
        check("post_reset_b0", b0, 64'd0);

        // drop_cnt saturation in EMPTY.
        repeat (260) begin
            adc_strobe = 1'b1;
            tick();
        end
        check("drop_saturate", 64'(drop_cnt), 64'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end
endmodule
